// File: rtl/light_pkg.sv
// Shared types for the light fader/selector: channel width, RGB struct, white constant
// and the fade FSM state encoding.
package light_pkg;

    localparam int LP_CW = 8;

    typedef struct packed {
        logic [LP_CW-1:0] r;
        logic [LP_CW-1:0] g;
        logic [LP_CW-1:0] b;
    } rgb_t;

    localparam rgb_t WHITE = '{r: '1, g: '1, b: '1};

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } fade_state_t;

endpackage

// File: rtl/light_ch_fader.sv
// One colour channel of the fader: moves cur toward tgt by STEP on a tick, snapping
// to tgt when it is within STEP so the value never overshoots or wraps.
module light_ch_fader
    import light_pkg::*;
#(
    parameter int CW   = LP_CW,
    parameter int STEP = 16
) (
    input  logic [CW-1:0] i_cur,
    input  logic [CW-1:0] i_tgt,
    input  logic          i_tick,
    output logic [CW-1:0] o_next,
    output logic          o_at_tgt
);

    localparam logic [CW-1:0] LP_STEP = STEP[CW-1:0];

    logic [CW-1:0] w_diff;
    logic [CW-1:0] w_stepped;

    always_comb begin
        w_diff    = '0;
        w_stepped = i_tgt;
        if (i_tgt >= i_cur) begin
            w_diff = i_tgt - i_cur;
            if (w_diff > LP_STEP) begin
                w_stepped = i_cur + LP_STEP;
            end
        end else begin
            w_diff = i_cur - i_tgt;
            if (w_diff > LP_STEP) begin
                w_stepped = i_cur - LP_STEP;
            end
        end
    end

    assign o_next   = i_tick ? w_stepped : i_cur;
    assign o_at_tgt = (o_next == i_tgt);

endmodule

// File: rtl/light_fader_selector.sv
// Selects one of NSRC RGB sources (out-of-range = white) and crossfades to each new selection.
// Optional output dimmer stage enabled by defining LIGHT_FADER_DIM_EN.
module light_fader_selector
    import light_pkg::*;
#(
    parameter int CW       = LP_CW,
    parameter int NSRC     = 4,
    parameter int STEP     = 16,
    parameter int TICK_DIV = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [$clog2(NSRC)-1:0]  i_sel,
    input  logic [NSRC*3*CW-1:0]     i_src,
`ifdef LIGHT_FADER_DIM_EN
    input  logic [CW-1:0]            i_dim,
`endif
    output logic [3*CW-1:0]          o_light,
    output logic                     o_busy
);

    localparam int SW        = $clog2(NSRC);
    localparam int CNTW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TICK_LAST = TICK_DIV - 1;
    localparam int NSRC_I    = NSRC;

    localparam logic [CNTW-1:0] LP_TICK_LAST = TICK_LAST[CNTW-1:0];
    localparam logic [SW:0]     LP_NSRC      = NSRC_I[SW:0];

    fade_state_t     r_state, w_stateNext;
    logic [SW-1:0]   r_selQ, w_selQNext;
    logic [CNTW-1:0] r_cnt, w_cntNext;
    logic [3*CW-1:0] r_cur, w_curNext;
    logic [3*CW-1:0] w_tgt;
    logic [3*CW-1:0] w_stepped;
    logic [2:0]      w_atTgt;
    logic            w_tick;
    logic [3*CW-1:0] w_srcArr [NSRC];

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : gen_src
            assign w_srcArr[gi] = i_src[gi*3*CW +: 3*CW];
        end
    endgenerate

    // The target follows the live source, so a moving source is tracked even mid-fade.
    assign w_tgt  = ({1'b0, r_selQ} < LP_NSRC) ? w_srcArr[r_selQ] : '1;
    assign w_tick = (r_cnt == LP_TICK_LAST);

    generate
        for (gi = 0; gi < 3; gi++) begin : gen_ch
            light_ch_fader #(
                .CW   (CW),
                .STEP (STEP)
            ) u_ch (
                .i_cur    (r_cur[gi*CW +: CW]),
                .i_tgt    (w_tgt[gi*CW +: CW]),
                .i_tick   (w_tick),
                .o_next   (w_stepped[gi*CW +: CW]),
                .o_at_tgt (w_atTgt[gi])
            );
        end
    endgenerate

    always_comb begin
        w_stateNext = r_state;
        w_selQNext  = r_selQ;
        w_cntNext   = r_cnt;
        w_curNext   = r_cur;
        case (r_state)
            IDLE: begin
                if (i_sel != r_selQ) begin
                    w_selQNext  = i_sel;
                    w_cntNext   = '0;
                    w_stateNext = FADE;
                end else begin
                    w_curNext = w_tgt;
                end
            end
            FADE: begin
                w_cntNext = w_tick ? '0 : r_cnt + 1'b1;
                w_curNext = w_stepped;
                // A new selection outranks completion; the tick counter keeps its cadence.
                if (i_sel != r_selQ) begin
                    w_selQNext = i_sel;
                end else if (&w_atTgt) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_selQ  <= '0;
            r_cnt   <= '0;
            r_cur   <= '1;
        end else begin
            r_state <= w_stateNext;
            r_selQ  <= w_selQNext;
            r_cnt   <= w_cntNext;
            r_cur   <= w_curNext;
        end
    end

    assign o_busy = (r_state == FADE);

`ifdef LIGHT_FADER_DIM_EN
    localparam int PW = 2 * CW;

    logic [3*CW-1:0] r_light;
    logic [3*CW-1:0] w_dimmed;

    // Scaling by (dim+1) >> CW makes full-scale dim an exact pass-through.
    generate
        for (gi = 0; gi < 3; gi++) begin : gen_dim
            assign w_dimmed[gi*CW +: CW] =
                CW'((PW'(r_cur[gi*CW +: CW]) * (PW'(i_dim) + PW'(1))) >> CW);
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_light <= '1;
        end else begin
            r_light <= w_dimmed;
        end
    end

    assign o_light = r_light;
`else
    assign o_light = r_cur;
`endif

endmodule

// File: tb/tb_light_fader_selector.sv
// Self-checking bench for light_fader_selector: directed scenarios plus randomized traffic
// against a behavioural colour model, on a 4-source and a 3-source instance.
module tb_light_fader_selector;

    localparam int STEP     = 16;
    localparam int TICK_DIV = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  sel;
    logic [95:0] src;
    logic [23:0] light4, light3;
    logic        busy4, busy3;
`ifdef LIGHT_FADER_DIM_EN
    logic [7:0]  dim;
`endif

    int nChecks = 0;
    int nFails  = 0;

    int          mSelQ [2];
    int          mCnt  [2];
    bit          mFade [2];
    logic [23:0] mCur  [2];
    logic [23:0] mLight[2];

    always #5 clk = ~clk;

    light_fader_selector #(.CW(8), .NSRC(4), .STEP(STEP), .TICK_DIV(TICK_DIV)) u_dut4 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_sel   (sel),
        .i_src   (src),
`ifdef LIGHT_FADER_DIM_EN
        .i_dim   (dim),
`endif
        .o_light (light4),
        .o_busy  (busy4)
    );

    light_fader_selector #(.CW(8), .NSRC(3), .STEP(STEP), .TICK_DIV(TICK_DIV)) u_dut3 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_sel   (sel),
        .i_src   (src[71:0]),
`ifdef LIGHT_FADER_DIM_EN
        .i_dim   (dim),
`endif
        .o_light (light3),
        .o_busy  (busy3)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: observed %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int stepToward(input int cur, input int tgt);
        int d;
        d = tgt - cur;
        if (d <= STEP && d >= -STEP) return tgt;
        return (d > 0) ? cur + STEP : cur - STEP;
    endfunction

    function automatic logic [23:0] targetOf(input int k);
        int nsrc;
        nsrc = (k == 0) ? 4 : 3;
        if (mSelQ[k] < nsrc) return src[mSelQ[k]*24 +: 24];
        return 24'hFFFFFF;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mSelQ[k]  = 0;
            mCnt[k]   = 0;
            mFade[k]  = 1'b0;
            mCur[k]   = 24'hFFFFFF;
            mLight[k] = 24'hFFFFFF;
        end
    endtask

    // Advance the colour model by one clock using the inputs currently applied.
    task automatic modelStep();
        logic [23:0] tgt;
        for (int k = 0; k < 2; k++) begin
            tgt = targetOf(k);
`ifdef LIGHT_FADER_DIM_EN
            for (int c = 0; c < 3; c++) begin
                int v;
                v = int'(mCur[k][c*8 +: 8]) * (int'(dim) + 1);
                mLight[k][c*8 +: 8] = 8'(v >> 8);
            end
`endif
            if (!mFade[k]) begin
                if (int'(sel) != mSelQ[k]) begin
                    mSelQ[k] = int'(sel);
                    mCnt[k]  = 0;
                    mFade[k] = 1'b1;
                end else begin
                    mCur[k] = tgt;
                end
            end else begin
                if (mCnt[k] == TICK_DIV - 1) begin
                    mCnt[k] = 0;
                    for (int c = 0; c < 3; c++) begin
                        mCur[k][c*8 +: 8] = 8'(stepToward(int'(mCur[k][c*8 +: 8]), int'(tgt[c*8 +: 8])));
                    end
                end else begin
                    mCnt[k]++;
                end
                if (int'(sel) != mSelQ[k]) mSelQ[k] = int'(sel);
                else if (mCur[k] == tgt) mFade[k] = 1'b0;
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [1:0] s, input logic [95:0] sr);
        rst_n = r;
        sel   = s;
        src   = sr;
        if (!r) modelReset();
        else modelStep();
    endtask

    task automatic checkModel();
        logic [23:0] exp4, exp3;
`ifdef LIGHT_FADER_DIM_EN
        exp4 = mLight[0];
        exp3 = mLight[1];
`else
        exp4 = mCur[0];
        exp3 = mCur[1];
`endif
        checkOutput("model_light4", light4, exp4);
        checkOutput("model_busy4",  busy4,  mFade[0]);
        checkOutput("model_light3", light3, exp3);
        checkOutput("model_busy3",  busy3,  mFade[1]);
    endtask

    task automatic runCycle(input logic r, input logic [1:0] s, input logic [95:0] sr);
        applyStimulus(r, s, sr);
        @(posedge clk);
        @(negedge clk);
        checkModel();
    endtask

    task automatic checkLight(input string tag, input logic [23:0] expLight, input logic expBusy);
        checkOutput({tag, "_light"}, light4, expLight);
        checkOutput({tag, "_busy"},  busy4,  expBusy);
    endtask

    logic [95:0] S2, S3, S1, sr;
    logic [7:0]  expR   [9] = '{8'h00, 8'h00, 8'h10, 8'h10, 8'h20, 8'h20, 8'h30, 8'h30, 8'h40};
    logic [23:0] expSnap[7] = '{24'h000000, 24'h000000, 24'h100505, 24'h100505,
                                24'h200505, 24'h200505, 24'h250505};
    logic        r;
    logic [1:0]  s;

    initial begin
        S2 = 96'h000000_000000_400000_000000;
        S3 = 96'h000000_250505_400000_000000;
        S1 = 96'h000000_250505_400000_102030;
`ifdef LIGHT_FADER_DIM_EN
        dim = 8'hFF;
`endif
        rst_n = 1'b0;
        sel   = 2'd0;
        src   = '0;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("reset_light", light4, 24'hFFFFFF);
        checkOutput("reset_busy",  busy4,  1'b0);

        // Plain fade 0 -> 400000
        repeat (3) runCycle(1'b1, 2'd0, S2);
        for (int k = 0; k < 9; k++) begin
            runCycle(1'b1, 2'd1, S2);
`ifndef LIGHT_FADER_DIM_EN
            checkLight($sformatf("fade_up_%0d", k), {expR[k], 16'h0000}, k < 8);
`endif
        end

        // Back down, then retarget mid-fade at R=20
        repeat (10) runCycle(1'b1, 2'd0, S2);
        repeat (5) runCycle(1'b1, 2'd1, S2);
`ifndef LIGHT_FADER_DIM_EN
        checkLight("retarget_at20", 24'h200000, 1'b1);
`endif
        runCycle(1'b1, 2'd0, S2);
        runCycle(1'b1, 2'd0, S2);
`ifndef LIGHT_FADER_DIM_EN
        checkLight("retarget_down1", 24'h100000, 1'b1);
`endif
        runCycle(1'b1, 2'd0, S2);
        runCycle(1'b1, 2'd0, S2);
`ifndef LIGHT_FADER_DIM_EN
        checkLight("retarget_done", 24'h000000, 1'b0);
`endif

        // Snap on final step; G,B snap on first tick
        for (int k = 0; k < 7; k++) begin
            runCycle(1'b1, 2'd2, S3);
`ifndef LIGHT_FADER_DIM_EN
            checkLight($sformatf("snap_%0d", k), expSnap[k], k < 6);
`endif
        end

        // Out-of-range select on the 3-source instance fades to white
        repeat (10) runCycle(1'b1, 2'd0, S3);
        repeat (32) runCycle(1'b1, 2'd3, S3);
`ifndef LIGHT_FADER_DIM_EN
        checkOutput("oor_tick15_light", light3, 24'hF0F0F0);
        checkOutput("oor_tick15_busy",  busy3,  1'b1);
`endif
        runCycle(1'b1, 2'd3, S3);
`ifndef LIGHT_FADER_DIM_EN
        checkOutput("oor_done_light", light3, 24'hFFFFFF);
        checkOutput("oor_done_busy",  busy3,  1'b0);
`endif

        // Asynchronous reset in the middle of a fade
        repeat (4) runCycle(1'b1, 2'd0, S3);
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("async_rst_light4", light4, 24'hFFFFFF);
        checkOutput("async_rst_busy4",  busy4,  1'b0);
        checkOutput("async_rst_light3", light3, 24'hFFFFFF);
        checkOutput("async_rst_busy3",  busy3,  1'b0);
        runCycle(1'b0, 2'd0, S1);
        runCycle(1'b1, 2'd0, S1);
`ifndef LIGHT_FADER_DIM_EN
        checkLight("reset_release", 24'h102030, 1'b0);
`endif

`ifdef LIGHT_FADER_DIM_EN
        S1[23:0] = 24'hFFFFFF;
        repeat (3) runCycle(1'b1, 2'd0, S1);
        dim = 8'h7F;
        runCycle(1'b1, 2'd0, S1);
        checkOutput("dim_7f", light4, 24'h7F7F7F);
        dim = 8'hFF;
        runCycle(1'b1, 2'd0, S1);
        checkOutput("dim_ff", light4, 24'hFFFFFF);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 299) != 0);
            s  = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : sel;
            sr = src;
            if ($urandom_range(0, 31) == 0) begin
                sr[$urandom_range(0, 3)*24 +: 24] = 24'($urandom);
            end
`ifdef LIGHT_FADER_DIM_EN
            if ($urandom_range(0, 19) == 0) dim = 8'($urandom);
`endif
            runCycle(r, s, sr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
